// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad scanner: FSM states, matrix
// geometry, and the helpers that decode a single-zero row or column vector.
`timescale 1ns/1ps
package lock_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } scan_state_e;

   localparam int unsigned NUM_ROWS = 4;
   localparam int unsigned NUM_COLS = 3;
   localparam int unsigned CNT_W    = 16;

   localparam logic [NUM_ROWS-1:0] ROW_IDLE  = 4'b1111;
   localparam logic [NUM_COLS-1:0] COL_FIRST = 3'b110;

   typedef struct packed {
      logic       single;  // exactly one line pulled low
      logic [1:0] index;   // position of the lowest zero
   } zero_pos_t;

   function automatic zero_pos_t row_zero(input logic [NUM_ROWS-1:0] v);
      zero_pos_t  r;
      logic [2:0] zeros;
      r     = '0;
      zeros = '0;
      for (int unsigned i = 0; i < NUM_ROWS; i++) begin
         if (!v[i]) begin
            if (zeros == 3'd0) begin
               r.index = 2'(i);
            end
            zeros = zeros + 3'd1;
         end
      end
      r.single = (zeros == 3'd1);
      return r;
   endfunction

   function automatic logic [1:0] col_index(input logic [NUM_COLS-1:0] c);
      logic [1:0] idx;
      case (c)
         3'b110:  idx = 2'd0;
         3'b101:  idx = 2'd1;
         3'b011:  idx = 2'd2;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   function automatic logic [NUM_COLS-1:0] col_next(input logic [NUM_COLS-1:0] c);
      return {c[NUM_COLS-2:0], c[NUM_COLS-1]};
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/keypad_scanner_row_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad row lines.
`timescale 1ns/1ps
module row_sync
   import lock_pkg::*;
#(
   parameter int unsigned WIDTH = NUM_ROWS
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   // Reset to all ones so the idle (released) level is seen during reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         meta_q <= '1;
         sync_q <= '1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: walks the columns, debounces row activity,
// and reports one key code per accepted press.
`timescale 1ns/1ps
module keypad_scanner
   import lock_pkg::*;
#(
   parameter int unsigned SCAN_CYCLES     = 1000,
   parameter int unsigned DEBOUNCE_CYCLES = 500
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [NUM_ROWS-1:0] row,
   output logic [NUM_COLS-1:0] col,
   output logic                key_valid,
   output logic [3:0]          key_code
);

   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [NUM_ROWS-1:0] rs;

   scan_state_e         state_q,     state_d;
   logic [NUM_COLS-1:0] col_q,       col_d;
   logic [CNT_W-1:0]    scan_cnt_q,  scan_cnt_d;
   logic [CNT_W-1:0]    stab_cnt_q,  stab_cnt_d;
   logic [NUM_ROWS-1:0] cap_q,       cap_d;
   logic                key_valid_q, key_valid_d;
   logic [3:0]          key_code_q,  key_code_d;

   zero_pos_t           cap_pos;
   logic [3:0]          row_idx4;
   logic [3:0]          col_idx4;

   row_sync #(
      .WIDTH (NUM_ROWS)
   ) u_row_sync (
      .clk_i  (clock),
      .rst_ni (reset),
      .d_i    (row),
      .q_o    (rs)
   );

   assign cap_pos  = row_zero(cap_q);
   assign row_idx4 = {2'b00, cap_pos.index};
   assign col_idx4 = {2'b00, col_index(col_q)};

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= SCAN;
         col_q       <= COL_FIRST;
         scan_cnt_q  <= '0;
         stab_cnt_q  <= '0;
         cap_q       <= ROW_IDLE;
         key_valid_q <= 1'b0;
         key_code_q  <= '0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         scan_cnt_q  <= scan_cnt_d;
         stab_cnt_q  <= stab_cnt_d;
         cap_q       <= cap_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      scan_cnt_d  = scan_cnt_q;
      stab_cnt_d  = stab_cnt_q;
      cap_d       = cap_q;
      key_valid_d = 1'b0;
      key_code_d  = key_code_q;

      case (state_q)
         SCAN: begin
            if (rs != ROW_IDLE) begin
               state_d    = DEBOUNCE;
               cap_d      = rs;
               stab_cnt_d = '0;
            end else if (scan_cnt_q >= SCAN_LAST) begin
               scan_cnt_d = '0;
               col_d      = col_next(col_q);
            end else begin
               scan_cnt_d = sat_inc(scan_cnt_q);
            end
         end

         DEBOUNCE: begin
            // Acting on the sample that would lift the count to
            // DEBOUNCE_CYCLES lets the output register land on that edge.
            if (rs != cap_q) begin
               cap_d      = rs;
               stab_cnt_d = '0;
            end else if (stab_cnt_q >= DEB_LAST) begin
               stab_cnt_d = '0;
               if (cap_q == ROW_IDLE) begin
                  state_d    = SCAN;
                  scan_cnt_d = '0;
               end else begin
                  state_d = HELD;
                  if (cap_pos.single) begin
                     key_valid_d = 1'b1;
                     key_code_d  = 4'((row_idx4 * 4'd3) + col_idx4);
                  end
               end
            end else begin
               stab_cnt_d = sat_inc(stab_cnt_q);
            end
         end

         HELD: begin
            if (rs != ROW_IDLE) begin
               stab_cnt_d = '0;
            end else if (stab_cnt_q >= DEB_LAST) begin
               state_d    = SCAN;
               stab_cnt_d = '0;
               scan_cnt_d = '0;
               col_d      = col_next(col_q);
            end else begin
               stab_cnt_d = sat_inc(stab_cnt_q);
            end
         end

         default: begin
            state_d = SCAN;
         end
      endcase
   end

   assign col       = col_q;
   assign key_valid = key_valid_q;
   assign key_code  = key_code_q;

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_CYCLES, default 1000: clocks each column stays driven while scanning; legal range 2..65535.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500: consecutive stable clocks required to accept a press or a release; legal range 2..65535.
REQ-003 SHALL have port clock  input  1  system clock (50 MHz, 20 ns period).
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port row  input  4  keypad row lines; active-low; asynchronous to clock; bouncing.
REQ-006 SHALL have port col  output  3  keypad column drive; active-low; one-hot-zero.
REQ-007 SHALL have port key_valid  output  1  one-cycle pulse per accepted key press.
REQ-008 SHALL have port key_code  output  4  code of the last accepted key; held between pulses.

Function
REQ-009 SHALL pass row through a 2-flop synchronizer; all decisions use the synchronized value rs.
REQ-010 SHALL implement states SCAN, DEBOUNCE, HELD.
REQ-011 In SCAN, col SHALL cycle 3'b110 -> 3'b101 -> 3'b011 -> 3'b110, advancing every SCAN_CYCLES clocks.
REQ-012 In SCAN, rs != 4'b1111 SHALL move to DEBOUNCE, freeze col, capture rs, and clear the stable counter.
REQ-013 In DEBOUNCE, rs equal to the captured value SHALL increment the counter; any other value SHALL recapture and clear the counter.
REQ-014 In DEBOUNCE, rs == 4'b1111 held for DEBOUNCE_CYCLES SHALL return to SCAN with the same col and no pulse.
REQ-015 When the counter reaches DEBOUNCE_CYCLES with exactly one zero in the captured value, the block SHALL register key_code = row_index*3 + col_index (row_index 0..3 = position of the zero; col_index 0..2 = position of the zero in col), pulse key_valid for one cycle, and enter HELD.
REQ-016 A stable value with two or more zeros SHALL enter HELD with no pulse and key_code unchanged.
REQ-017 key_valid SHALL rise DEBOUNCE_CYCLES+3 clocks after the last row transition at the pin: 2 synchronizer stages, DEBOUNCE_CYCLES stable samples, 1 output register.
REQ-018 In HELD, col SHALL stay frozen; the block SHALL count consecutive rs == 4'b1111 clocks, and any zero SHALL clear the count.
REQ-019 HELD SHALL exit to SCAN after DEBOUNCE_CYCLES consecutive released clocks, advancing col by one position; release SHALL never pulse key_valid.
REQ-020 At most one key_valid pulse SHALL occur per DEBOUNCE -> HELD entry, regardless of bounce count.
REQ-021 Counters SHALL be 16 bits, SHALL saturate, and SHALL NOT wrap.

Reset
REQ-022 While reset == 0 at a clock edge: state = SCAN, col = 3'b110, key_valid = 0, key_code = 4'd0, counters = 0, synchronizer flops = 4'b1111.
REQ-023 Reset asserted mid-DEBOUNCE or mid-HELD SHALL abort with no pending pulse; scanning resumes from 3'b110 on the first clock after release.

Structure
REQ-024 Shared package lock_pkg SHALL hold the state enum (SCAN, DEBOUNCE, HELD), NUM_ROWS = 4, NUM_COLS = 3, and the idle row constant 4'b1111.
REQ-025 The synchronizer SHALL be the sub-module row_sync (4-bit, 2-flop, reset to all ones); all other logic lives in keypad_scanner.

Verification (SCAN_CYCLES = 8, DEBOUNCE_CYCLES = 500, 20 ns clock)
REQ-026 Reset low for 10 clocks -> col = 3'b110, key_valid = 0, key_code = 0 throughout and on the first clock after release.
REQ-027 row = 4'b1101 applied cleanly while col = 3'b110 and held 21 us -> exactly one key_valid pulse at 503 clocks, key_code = 3, col frozen at 3'b110 until release is debounced.
REQ-028 30 random row[1] toggles at 0..1022 ns intervals, then 4'b1101 for 21 us, then 30 toggles and 4'b1111 for 21 us, repeated 4 times -> exactly 4 pulses, none during release, and scanning resumes each time.
REQ-029 row = 4'b1100 held 21 us -> no pulse, key_code unchanged, col frozen until 4'b1111 has been stable for 500 clocks.
REQ-030 row low for 200 clocks then 4'b1111 -> no pulse and a return to SCAN; reset asserted at clock 300 of a 4'b1101 debounce -> no pulse and col = 3'b110.
